serial_add_arbiter: RTL and testbench

SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

---
 rtl/serial_add_arbiter.sv | 92 +++++++++
 tb/tb_serial_add_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin front end sharing one bit-serial adder.
// Each operation takes WIDTH add cycles plus one result cycle, then one idle cycle.
module serial_add_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic             res_id,
  output logic [WIDTH:0]   res_sum,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             id_reg, last_grant;
  logic             grant, accept, fa_sum, fa_carry;

  // Tie goes to whoever did not win last time; a lone requester always wins.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant;
    accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    fa_sum     = a_reg[0] ^ b_reg[0] ^ carry;
    fa_carry   = (a_reg[0] & b_reg[0]) | (carry & (a_reg[0] ^ b_reg[0]));
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      sum_reg    <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      id_reg     <= 1'b0;
      last_grant <= 1'b1;
      res_valid  <= 1'b0;
      res_id     <= 1'b0;
      res_sum    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg      <= grant ? req1_a : req0_a;
            b_reg      <= grant ? req1_b : req0_b;
            id_reg     <= grant;
            last_grant <= grant;
            carry      <= 1'b0;
            cnt        <= '0;
            state      <= ADD;
          end
        end
        ADD: begin
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          sum_reg <= {fa_sum, sum_reg[WIDTH-1:1]};
          carry   <= fa_carry;
          cnt     <= cnt + CW'(1);
          // Last bit: publish the result straight from the adder outputs.
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_sum   <= {fa_carry, fa_sum, sum_reg[WIDTH-1:1]};
            res_id    <= id_reg;
          end
        end
        DONE: begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed bench for serial_add_arbiter: latency, round-robin, capture, reset abort, carry.
module tb_serial_add_arbiter;
  localparam int WIDTH = 4;

  logic             clk, rst_n;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             req0_ready, req1_ready, res_valid, res_id, busy;
  logic [WIDTH:0]   res_sum;

  int checks = 0;
  int failures = 0;

  serial_add_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Steps negedges until res_valid is seen or the limit expires.
  task automatic wait_res(input int lim, output int n, output bit seen);
    seen = 0;
    n = 0;
    while (!seen && n < lim) begin
      @(negedge clk);
      n++;
      if (res_valid) seen = 1;
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    req0_valid = 1; req1_valid = 1;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, res_valid, req0_ready, req1_ready, res_id, res_sum} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b vld=%b rdy=%b%b id=%b sum=%b want all 0",
               busy, res_valid, req0_ready, req1_ready, res_id, res_sum);
    end
    req0_valid = 0; req1_valid = 0;
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int n; bit seen;
    req0_valid = 1; req0_a = 4'b1101; req0_b = 4'b1011;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++; $display("FAIL basic_ready got %b%b want 10", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 0;
    checks++;
    if (busy !== 1'b1 || req0_ready !== 1'b0) begin
      failures++; $display("FAIL basic_busy got busy=%b rdy=%b want 1 0", busy, req0_ready);
    end
    wait_res(10, n, seen);
    checks++;
    if (!seen || n != WIDTH) begin
      failures++; $display("FAIL basic_latency got seen=%0d n=%0d want n=%0d", seen, n, WIDTH);
    end
    checks++;
    if (res_id !== 1'b0 || res_sum !== 5'd24) begin
      failures++; $display("FAIL basic_result got id=%b sum=%0d want 0 24", res_id, res_sum);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || res_sum !== 5'd24 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_hold got vld=%b sum=%0d busy=%b want 0 24 0", res_valid, res_sum, busy);
    end
  endtask

  task automatic test_tie;
    int n; bit seen;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    req0_valid = 1; req0_a = 3;  req0_b = 4;
    req1_valid = 1; req1_a = 15; req1_b = 15;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++; $display("FAIL tie_first_grant got %b%b want 10", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 0;
    wait_res(10, n, seen);
    checks++;
    if (!seen || res_id !== 1'b0 || res_sum !== 5'b00111) begin
      failures++; $display("FAIL tie_req0 got seen=%0d id=%b sum=%b want 0 00111", seen, res_id, res_sum);
    end
    wait_res(12, n, seen);
    checks++;
    if (!seen || n != WIDTH + 2) begin
      failures++; $display("FAIL tie_gap got seen=%0d gap=%0d want %0d", seen, n, WIDTH + 2);
    end
    checks++;
    if (res_id !== 1'b1 || res_sum !== 5'b11110) begin
      failures++; $display("FAIL tie_req1 got id=%b sum=%b want 1 11110", res_id, res_sum);
    end
    req1_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    int n; bit seen;
    logic [WIDTH:0] want_sum;
    req0_valid = 1; req0_a = 1; req0_b = 2;
    req1_valid = 1; req1_a = 5; req1_b = 6;
    for (int i = 0; i < 4; i++) begin
      wait_res(12, n, seen);
      if (i == 3) begin
        req0_valid = 0; req1_valid = 0;
      end
      want_sum = (i % 2 == 0) ? 5'd3 : 5'd11;
      checks++;
      if (!seen || res_id !== 1'(i % 2) || res_sum !== want_sum) begin
        failures++;
        $display("FAIL rr_op%0d got seen=%0d id=%b sum=%0d want id=%0d sum=%0d",
                 i, seen, res_id, res_sum, i % 2, want_sum);
      end
      if (i > 0) begin
        checks++;
        if (n != WIDTH + 2) begin
          failures++; $display("FAIL rr_gap%0d got %0d want %0d", i, n, WIDTH + 2);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_capture;
    bit seen, rdy_bad;
    req1_valid = 1; req1_a = 9; req1_b = 5;
    @(negedge clk);
    req1_a = 15; req1_b = 15;
    seen = 0; rdy_bad = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (req0_ready || req1_ready) rdy_bad = 1;
      @(negedge clk);
      if (res_valid) seen = 1;
    end
    if (req0_ready || req1_ready) rdy_bad = 1;
    req1_valid = 0;
    checks++;
    if (rdy_bad) begin
      failures++; $display("FAIL capture_ready got ready=1 while busy want 0");
    end
    checks++;
    if (!seen || res_id !== 1'b1 || res_sum !== 5'd14) begin
      failures++; $display("FAIL capture_result got seen=%0d id=%b sum=%0d want 1 14", seen, res_id, res_sum);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int n; bit seen;
    req0_valid = 1; req0_a = 4'b1101; req0_b = 4'b1011;
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if ({busy, res_valid, req0_ready, req1_ready, res_id, res_sum} !== '0) begin
      failures++;
      $display("FAIL abort_outputs got busy=%b vld=%b rdy=%b%b id=%b sum=%b want all 0",
               busy, res_valid, req0_ready, req1_ready, res_id, res_sum);
    end
    @(negedge clk);
    rst_n = 1;
    wait_res(8, n, seen);
    checks++;
    if (seen) begin
      failures++; $display("FAIL abort_no_result got res_valid=1 want 0");
    end
    req0_valid = 1; req0_a = 2; req0_b = 3;
    req1_valid = 1; req1_a = 7; req1_b = 7;
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    wait_res(10, n, seen);
    checks++;
    if (!seen || res_id !== 1'b0 || res_sum !== 5'd5) begin
      failures++; $display("FAIL abort_resume got seen=%0d id=%b sum=%0d want 0 5", seen, res_id, res_sum);
    end
    @(negedge clk);
  endtask

  task automatic test_carry;
    int n; bit seen;
    logic [WIDTH-1:0] va [2] = '{4'd0, 4'd15};
    logic [WIDTH-1:0] vb [2] = '{4'd0, 4'd1};
    logic [WIDTH:0]   vs [2] = '{5'b00000, 5'b10000};
    for (int i = 0; i < 2; i++) begin
      req0_valid = 1; req0_a = va[i]; req0_b = vb[i];
      @(negedge clk);
      req0_valid = 0;
      wait_res(10, n, seen);
      checks++;
      if (!seen || res_sum !== vs[i] || res_sum[WIDTH] !== vs[i][WIDTH]) begin
        failures++;
        $display("FAIL carry_vec%0d got seen=%0d sum=%b want %b", i, seen, res_sum, vs[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_round_robin();
    test_capture();
    test_reset_abort();
    test_carry();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
